// File: rtl/otp_disp_capture.sv
// Capture side of the OTP display path: decodes the scanned seven-segment digits,
// qualifies them by stability and emits {otp,user} byte frames on a valid/ready port.
module otp_disp_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] lfsr_out,
  input  logic [6:0] user_out,
  input  logic [1:0] an,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic [7:0] otp_byte,
  output logic [7:0] user_byte,
  output logic       match,
  output logic       seg_err,
  output logic [7:0] overrun_cnt
);

  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_M1   = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_D0, WAIT_D1, EMIT} state_t;

  // Returns {valid, nibble} for an active-low segment pattern.
  function automatic logic [4:0] f_decode(input logic [6:0] seg_n);
    logic [6:0] seg;
    seg = ~seg_n;
    case (seg)
      7'h3F:   f_decode = {1'b1, 4'h0};
      7'h06:   f_decode = {1'b1, 4'h1};
      7'h5B:   f_decode = {1'b1, 4'h2};
      7'h4F:   f_decode = {1'b1, 4'h3};
      7'h66:   f_decode = {1'b1, 4'h4};
      7'h6D:   f_decode = {1'b1, 4'h5};
      7'h7D:   f_decode = {1'b1, 4'h6};
      7'h07:   f_decode = {1'b1, 4'h7};
      7'h7F:   f_decode = {1'b1, 4'h8};
      7'h6F:   f_decode = {1'b1, 4'h9};
      7'h77:   f_decode = {1'b1, 4'hA};
      7'h7C:   f_decode = {1'b1, 4'hB};
      7'h39:   f_decode = {1'b1, 4'hC};
      7'h5E:   f_decode = {1'b1, 4'hD};
      7'h79:   f_decode = {1'b1, 4'hE};
      7'h71:   f_decode = {1'b1, 4'hF};
      default: f_decode = 5'h00;
    endcase
  endfunction

  function automatic logic f_valid(input logic [6:0] seg_n);
    logic [4:0] d;
    d = f_decode(seg_n);
    return d[4];
  endfunction

  logic [1:0] r_an, r_an_prev;
  logic [6:0] r_lfsr, r_lfsr_prev, r_user, r_user_prev;
  logic [7:0] r_cnt;
  logic       r_seg_err;
  state_t     r_state;
  logic       r_frame_valid, r_match;
  logic [7:0] r_otp_byte, r_user_byte, r_overrun;

  logic [4:0] w_lfsr_dec, w_user_dec;
  logic       w_an_ok, w_smp_ok, w_same, w_accept;
  logic       w_pin_an_ok, w_pin_ok, w_pin_diff;
  logic       w_emit;
  logic [1:0] w_acc, w_got;
  logic [7:0] w_dig_otp, w_dig_user;

  assign w_lfsr_dec = f_decode(r_lfsr);
  assign w_user_dec = f_decode(r_user);
  assign w_an_ok    = (r_an == 2'b10) || (r_an == 2'b01);
  assign w_smp_ok   = w_an_ok & w_lfsr_dec[4] & w_user_dec[4];
  assign w_same     = ({r_an, r_lfsr, r_user} == {r_an_prev, r_lfsr_prev, r_user_prev});
  // Fires exactly once per stable run: on the step from STABLE-1 to STABLE.
  assign w_accept   = w_smp_ok & w_same & (r_cnt == STABLE_M1);

  // Error detection looks at the pins so the pulse lands one cycle after the bad
  // pattern appears; it re-fires only when the sampled pattern changes.
  assign w_pin_an_ok = (an == 2'b10) || (an == 2'b01);
  assign w_pin_ok    = f_valid(lfsr_out) & f_valid(user_out);
  assign w_pin_diff  = ({an, lfsr_out, user_out} != {r_an, r_lfsr, r_user});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an        <= '0;
      r_lfsr      <= '0;
      r_user      <= '0;
      r_an_prev   <= '0;
      r_lfsr_prev <= '0;
      r_user_prev <= '0;
      r_seg_err   <= 1'b0;
    end else begin
      r_an        <= an;
      r_lfsr      <= lfsr_out;
      r_user      <= user_out;
      r_an_prev   <= r_an;
      r_lfsr_prev <= r_lfsr;
      r_user_prev <= r_user;
      r_seg_err   <= w_pin_an_ok & ~w_pin_ok & w_pin_diff;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (!w_smp_ok)
      r_cnt <= '0;
    else if (!w_same)
      r_cnt <= 8'd1;
    else if (r_cnt != STABLE_LAST)
      r_cnt <= r_cnt + 8'd1;
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_slot
    localparam logic [1:0] AN_SEL = (gi == 0) ? 2'b10 : 2'b01;
    logic [3:0] r_otp, r_usr;
    logic       r_got;

    assign w_acc[gi] = w_accept & (r_an == AN_SEL);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_otp <= '0;
        r_usr <= '0;
        r_got <= 1'b0;
      end else if (w_acc[gi]) begin
        r_otp <= w_lfsr_dec[3:0];
        r_usr <= w_user_dec[3:0];
        r_got <= 1'b1;
      end
    end

    assign w_dig_otp[gi*4 +: 4]  = r_otp;
    assign w_dig_user[gi*4 +: 4] = r_usr;
    assign w_got[gi]             = r_got;
  end

  assign w_emit = (r_state == EMIT) & w_got[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= WAIT_D0;
      r_frame_valid <= 1'b0;
      r_otp_byte    <= '0;
      r_user_byte   <= '0;
      r_match       <= 1'b0;
      r_overrun     <= '0;
    end else begin
      case (r_state)
        WAIT_D0: if (w_acc[0]) r_state <= WAIT_D1;
        WAIT_D1: if (w_acc[1] && w_got[0]) r_state <= EMIT;
        EMIT:    r_state <= WAIT_D0;
        default: r_state <= WAIT_D0;
      endcase

      // A handshake in the EMIT cycle frees the register, so the new frame loads.
      if (w_emit) begin
        if (!r_frame_valid || frame_ready) begin
          r_frame_valid <= 1'b1;
          r_otp_byte    <= w_dig_otp;
          r_user_byte   <= w_dig_user;
          r_match       <= (w_dig_otp == w_dig_user);
        end else if (r_overrun != 8'hFF) begin
          r_overrun <= r_overrun + 8'd1;
        end
      end else if (r_frame_valid && frame_ready) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign frame_valid = r_frame_valid;
  assign otp_byte    = r_otp_byte;
  assign user_byte   = r_user_byte;
  assign match       = r_match;
  assign seg_err     = r_seg_err;
  assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_otp_disp_capture.sv
// Directed test-plan steps followed by random scans, checked every cycle against
// a pin-level model of digit runs, frame assembly and the output handshake.
module tb_otp_disp_capture;

  localparam int STABLE = 4;
  localparam logic [6:0] S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, OFF = 7'h7F;
  localparam logic [1:0] D0 = 2'b10, D1 = 2'b01, BL = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] lfsr_out = OFF, user_out = OFF;
  logic [1:0] an = BL;
  logic       frame_ready = 1'b0;
  logic       frame_valid, match, seg_err;
  logic [7:0] otp_byte, user_byte, overrun_cnt;

  otp_disp_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .reset(reset), .lfsr_out(lfsr_out), .user_out(user_out), .an(an),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .otp_byte(otp_byte),
    .user_byte(user_byte), .match(match), .seg_err(seg_err), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: pin history, pending accept/emit events and the output register.
  logic [15:0] m_prev;
  int          m_held;
  logic        m_acc_pend, m_acc_slot, m_have_d0, m_emit_pend;
  logic [3:0]  m_acc_o, m_acc_u, m_d0o, m_d0u;
  logic [7:0]  m_fr_o, m_fr_u, m_ob, m_ub, m_ovr;
  logic        m_v, m_match, m_seg;

  function automatic int tb_decode(input logic [6:0] seg_n);
    logic [6:0] hi;
    hi = ~seg_n;
    for (int i = 0; i < 16; i++)
      if (hi == SEG_TAB[i]) return i;
    return -1;
  endfunction

  function automatic logic [6:0] enc(input int n);
    return ~SEG_TAB[n];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%02h expected=%02h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = '0; m_held = 0; m_acc_pend = 0; m_acc_slot = 0; m_have_d0 = 0;
    m_emit_pend = 0; m_acc_o = '0; m_acc_u = '0; m_d0o = '0; m_d0u = '0;
    m_fr_o = '0; m_fr_u = '0; m_ob = '0; m_ub = '0; m_ovr = '0;
    m_v = 0; m_match = 0; m_seg = 0;
  endtask

  // Expected state just after the coming clock edge, given the pins/ready before it.
  task automatic model_edge(input logic [1:0] a, input logic [6:0] l, input logic [6:0] u,
                            input logic r);
    logic        emit_now, an_ok;
    logic [7:0]  fo, fu;
    logic [15:0] cur;
    int          dl, du;
    emit_now = m_emit_pend; fo = m_fr_o; fu = m_fr_u;
    m_emit_pend = 0;
    if (m_acc_pend) begin
      if (!m_acc_slot) begin
        m_d0o = m_acc_o; m_d0u = m_acc_u; m_have_d0 = 1;
      end else if (m_have_d0) begin
        m_emit_pend = 1; m_have_d0 = 0;
        m_fr_o = {m_acc_o, m_d0o}; m_fr_u = {m_acc_u, m_d0u};
      end
      m_acc_pend = 0;
    end
    if (emit_now) begin
      if (!m_v || r) begin
        m_v = 1; m_ob = fo; m_ub = fu; m_match = (fo == fu);
      end else if (m_ovr != 8'hFF) begin
        m_ovr = m_ovr + 8'd1;
      end
    end else if (m_v && r) begin
      m_v = 0;
    end
    cur = {a, l, u};
    m_held = (cur == m_prev) ? m_held + 1 : 1;
    an_ok = (a == D0) || (a == D1);
    dl = tb_decode(l);
    du = tb_decode(u);
    m_seg = an_ok && (dl < 0 || du < 0) && (cur != m_prev);
    if (an_ok && dl >= 0 && du >= 0 && m_held == STABLE) begin
      m_acc_pend = 1; m_acc_slot = (a == D1); m_acc_o = 4'(dl); m_acc_u = 4'(du);
    end
    m_prev = cur;
  endtask

  task automatic step(input logic [1:0] a, input logic [6:0] l, input logic [6:0] u,
                      input logic r);
    @(negedge clk);
    an = a; lfsr_out = l; user_out = u; frame_ready = r;
    model_edge(a, l, u, r);
    @(posedge clk);
    #1;
    check("frame_valid", {7'b0, frame_valid}, {7'b0, m_v});
    if (m_v) begin
      check("otp_byte", otp_byte, m_ob);
      check("user_byte", user_byte, m_ub);
      check("match", {7'b0, match}, {7'b0, m_match});
    end
    check("overrun_cnt", overrun_cnt, m_ovr);
    check("seg_err", {7'b0, seg_err}, {7'b0, m_seg});
  endtask

  task automatic hold(input logic [1:0] a, input logic [6:0] l, input logic [6:0] u,
                      input int n, input logic r);
    for (int k = 0; k < n; k++) step(a, l, u, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_valid", {7'b0, frame_valid}, 8'h00);
    check("rst_otp", otp_byte, 8'h00);
    check("rst_user", user_byte, 8'h00);
    check("rst_match", {7'b0, match}, 8'h00);
    check("rst_seg_err", {7'b0, seg_err}, 8'h00);
    check("rst_overrun", overrun_cnt, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] a;
    logic [6:0] l, u;
    int         len, sel;

    do_reset();

    // Basic frame, then handshake.
    hold(D0, S1, S1, 4, 0); hold(D1, S2, S2, 4, 0);
    hold(BL, OFF, OFF, 1, 0);
    check("basic_early", {7'b0, frame_valid}, 8'h00);
    hold(BL, OFF, OFF, 1, 0);
    check("basic_valid", {7'b0, frame_valid}, 8'h01);
    check("basic_otp", otp_byte, 8'h21);
    check("basic_user", user_byte, 8'h21);
    check("basic_match", {7'b0, match}, 8'h01);
    hold(BL, OFF, OFF, 1, 1);
    check("basic_drop", {7'b0, frame_valid}, 8'h00);

    // Mismatching user digit.
    hold(D0, S1, S1, 4, 0); hold(D1, S2, S3, 4, 0); hold(BL, OFF, OFF, 2, 0);
    check("mm_otp", otp_byte, 8'h21);
    check("mm_user", user_byte, 8'h31);
    check("mm_match", {7'b0, match}, 8'h00);
    hold(BL, OFF, OFF, 1, 1);

    // Three-cycle digit0 is not accepted; four cycles is.
    hold(D0, S1, S1, 3, 0); hold(BL, OFF, OFF, 1, 0);
    hold(D1, S2, S2, 4, 0); hold(BL, OFF, OFF, 3, 0);
    check("short_noframe", {7'b0, frame_valid}, 8'h00);
    hold(D0, S1, S1, 4, 0); hold(D1, S2, S2, 4, 0); hold(BL, OFF, OFF, 2, 0);
    check("stable_valid", {7'b0, frame_valid}, 8'h01);
    hold(BL, OFF, OFF, 1, 1);

    // Undecodable pattern under a valid anode.
    hold(D0, OFF, S1, 1, 0);
    check("bad_pulse", {7'b0, seg_err}, 8'h01);
    hold(D0, OFF, S1, 2, 0);
    check("bad_pulse_end", {7'b0, seg_err}, 8'h00);
    hold(D1, S2, S2, 4, 0); hold(BL, OFF, OFF, 3, 0);
    check("bad_noframe", {7'b0, frame_valid}, 8'h00);

    // Overrun while stalled, then a new frame loading on the handshake cycle.
    hold(D0, S1, S1, 4, 0); hold(D1, S2, S2, 4, 0); hold(BL, OFF, OFF, 2, 0);
    hold(D0, S3, S3, 4, 0); hold(D1, S4, S4, 4, 0); hold(BL, OFF, OFF, 2, 0);
    check("ovr_otp", otp_byte, 8'h21);
    check("ovr_cnt", overrun_cnt, 8'h01);
    hold(D0, S5, S5, 4, 0); hold(D1, S6, S6, 4, 0);
    hold(BL, OFF, OFF, 1, 0); hold(BL, OFF, OFF, 1, 1);
    check("swap_valid", {7'b0, frame_valid}, 8'h01);
    check("swap_otp", otp_byte, 8'h65);
    check("swap_cnt", overrun_cnt, 8'h01);
    hold(BL, OFF, OFF, 1, 1);
    check("swap_drop", {7'b0, frame_valid}, 8'h00);

    // Reset after digit0 accept discards the partial frame.
    hold(D0, S1, S1, 4, 0); hold(BL, OFF, OFF, 2, 0);
    do_reset();
    hold(D1, S2, S2, 4, 0); hold(BL, OFF, OFF, 3, 0);
    check("rst_noframe", {7'b0, frame_valid}, 8'h00);
    hold(D0, S1, S1, 4, 0); hold(D1, S2, S2, 4, 0); hold(BL, OFF, OFF, 2, 0);
    check("rst_frame_otp", otp_byte, 8'h21);
    hold(BL, OFF, OFF, 1, 1);

    // Random scans with random back-pressure.
    for (int run = 0; run < 80; run++) begin
      sel = int'($urandom_range(0, 9));
      a = (sel < 4) ? D0 : (sel < 8) ? D1 : (sel == 8) ? BL : 2'b00;
      l = ($urandom_range(0, 99) < 88) ? enc(int'($urandom_range(0, 15))) : 7'($urandom);
      u = ($urandom_range(0, 99) < 88) ? enc(int'($urandom_range(0, 15))) : 7'($urandom);
      len = int'($urandom_range(1, 7));
      for (int k = 0; k < len; k++) step(a, l, u, 1'($urandom_range(0, 1)));
    end
    hold(BL, OFF, OFF, 5, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/otp_disp_capture.md
# otp_disp_capture

Bench- and board-side capture block for the OTP authenticator's multiplexed two-digit seven-segment output. It consumes the scanned segment buses (`lfsr_out`, `user_out`) and the anode select (`an`), decodes each digit back to a hex nibble, and qualifies digits by stability. It reassembles full 8-bit OTP and user values and presents them as a frame on a valid/ready handshake. It sits on the far end of the display path: the reader for the authenticator's display writer.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required to accept a digit (legal range 2..255).
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `lfsr_out` in 7: OTP digit segments, active-low, bit0=a … bit6=g.
- `user_out` in 7: user digit segments, same encoding.
- `an` in 2: active-low anode enable. 2'b10 selects digit0 (low nibble); 2'b01 selects digit1 (high nibble); 2'b00 and 2'b11 are blank.
- `frame_valid` out 1: captured frame available.
- `frame_ready` in 1: consumer accepts the frame.
- `otp_byte` out 8: captured OTP value {digit1, digit0}.
- `user_byte` out 8: captured user value.
- `match` out 1: `otp_byte == user_byte`.
- `seg_err` out 1: one-cycle pulse when an undecodable segment pattern is sampled under a valid anode.
- `overrun_cnt` out 8: frames dropped while a frame was pending; saturates at 8'hFF.

## Operation
- Decode: invert segments to active-high, then map to nibbles. 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71. Any other pattern is invalid.
- Sampling: inputs are registered every cycle. The stability counter increments when the current sample ({an, lfsr_out, user_out}) equals the previous sample and both patterns are valid. Otherwise the counter reloads to 1 (valid) or 0 (invalid or blank).
- Digit accept: when the counter reaches `STABLE_CYCLES`, latch the decoded OTP and user nibbles into the digit slot selected by `an` and set that slot's `got` flag. Accept fires once per stable run; the counter holds until the sample changes.
- Blank anode: resets the counter only. Latched digits and `got` flags are kept.
- Invalid pattern under a valid anode: pulse `seg_err`, reset the counter.
- Capture FSM states:
  - WAIT_D0: waits for a digit0 accept, then goes to WAIT_D1. A digit1 accept here is latched but does not advance.
  - WAIT_D1: waits for a digit1 accept, then goes to EMIT. A new digit0 accept here overwrites digit0 and stays in WAIT_D1.
  - EMIT: one cycle. Builds the frame from the latched nibbles and returns to WAIT_D0.
- Output register: in EMIT, if `frame_valid`=0, load `otp_byte`, `user_byte`, `match` and set `frame_valid`. If `frame_valid`=1 and `frame_ready`=0, drop the new frame and increment `overrun_cnt` (saturating).
- Handshake: `frame_valid` falls the cycle after `frame_valid && frame_ready`. While valid, the data outputs are stable.
- Simultaneous EMIT and a handshake completing in the same cycle: the handshake retires the old frame, the new frame loads, `frame_valid` stays 1, and no overrun is counted.
- `match` is computed on the full 8 bits at load time.

## Timing
- Reset values: `frame_valid`=0, `otp_byte`=0, `user_byte`=0, `match`=0, `seg_err`=0, `overrun_cnt`=0, FSM=WAIT_D0, counter=0, `got` flags=0.
- Input register adds 1 cycle. A digit is accepted on the edge where the `STABLE_CYCLES`-th identical registered sample is seen.
- EMIT follows the digit1 accept by 1 cycle. `frame_valid` rises at the end of the EMIT cycle.
- Minimum latency from the first digit1 sample at the pins to `frame_valid`: `STABLE_CYCLES` + 2 cycles.
- `seg_err` asserts 1 cycle after the bad pattern appears at the pins.
- Reset mid-frame: asserting `reset` asynchronously clears everything. A partially captured frame is discarded; no output glitches beyond the reset values.

## Test plan
- Basic frame: `an`=10 with `lfsr_out`=`user_out`=7'h79 ("1") for 4 cycles, then `an`=01 with both =7'h24 ("2") for 4 cycles. Expect `frame_valid`=1 with `otp_byte`=8'h21, `user_byte`=8'h21, `match`=1, 6 cycles after the digit1 start.
- Mismatch: same as above but `user_out`=7'h30 ("3") during digit1. Expect `user_byte`=8'h31, `match`=0.
- Stability: digit0 held only 3 cycles, then changed. Expect no accept and no frame. Hold 4 cycles and the accept occurs.
- Invalid pattern: `an`=10, `lfsr_out`=7'h7F (all segments off). Expect a 1-cycle `seg_err`, counter cleared, and no frame.
- Overrun: hold `frame_ready`=0 and complete two frames (8'h21, then 8'h43). Expect `otp_byte` to stay 8'h21 and `overrun_cnt`=1. Raise `frame_ready`: `frame_valid` drops the next cycle.
- Reset mid-capture: assert `reset` in WAIT_D1 after digit0 has been accepted. After release, a lone digit1 run produces no frame; a full digit0 then digit1 sequence does.
